// File: rtl/spart_rx.sv
// SPART receiver: 16x oversampled async serial input with a bus-readable data register.
// Define SPART_RX_OVERRUN_EN to build the overrun flag; otherwise OERR is tied low.
module spart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  input  logic       Enable,
  input  logic       IORW,
  input  logic [1:0] IOADDR,
  output logic [7:0] RX_DATA,
  output logic       RDA,
  output logic       FERR,
  output logic       OERR
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_tick,  w_tick_nxt;
  logic [2:0] r_bit,   w_bit_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_rx_meta, r_rxs;
  logic       w_rd, w_good, w_bad;

  assign w_rd = IORW && (IOADDR == 2'b00);

  // Synchronizer runs every clk so the FSM always sees a settled line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= RxD;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick  <= 4'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    if (Enable) begin
      case (r_state)
        IDLE: begin
          if (!r_rxs) begin
            w_state_nxt = START;
            w_tick_nxt  = 4'd0;
          end
        end
        START: begin
          if (r_tick == 4'd7) begin
            w_tick_nxt = 4'd0;
            w_bit_nxt  = 3'd0;
            // Start bit gone high at mid-bit: treat as a glitch.
            w_state_nxt = r_rxs ? IDLE : DATA;
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end
        DATA: begin
          if (r_tick == 4'd15) begin
            w_shift_nxt = {r_rxs, r_shift[7:1]};
            w_tick_nxt  = 4'd0;
            w_bit_nxt   = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_nxt = STOP;
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end
        STOP: begin
          if (r_tick == 4'd15) begin
            w_good      = r_rxs;
            w_bad       = !r_rxs;
            w_tick_nxt  = 4'd0;
            w_state_nxt = IDLE;
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // A completing frame takes priority over a simultaneous data read.
  always_ff @(posedge clk) begin
    if (rst) begin
      RX_DATA <= 8'h00;
      RDA     <= 1'b0;
      FERR    <= 1'b0;
    end else begin
      if (w_good) begin
        RX_DATA <= r_shift;
        RDA     <= 1'b1;
        FERR    <= 1'b0;
      end else begin
        if (w_bad) FERR <= 1'b1;
        else if (w_rd) FERR <= 1'b0;
        if (w_rd) RDA <= 1'b0;
      end
    end
  end

`ifdef SPART_RX_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      OERR <= 1'b0;
    end else if (w_good && RDA && !w_rd) begin
      OERR <= 1'b1;
    end else if (w_rd) begin
      OERR <= 1'b0;
    end
  end
`else
  assign OERR = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: drives whole frames at 64 clk per bit and tracks
// the expected register state per frame/read in a small bench-side model.
module tb_spart_rx;

`ifdef SPART_RX_OVERRUN_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RxD = 1'b1;
  logic       Enable;
  logic       IORW = 1'b0;
  logic [1:0] IOADDR = 2'b00;
  logic [7:0] RX_DATA;
  logic       RDA, FERR, OERR;

  logic [1:0] ecnt = 2'd0;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_data = 8'h00;
  logic       m_rda  = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_oerr = 1'b0;
  bit         m_valid = 1'b0;

  spart_rx dut (
    .clk(clk), .rst(rst), .RxD(RxD), .Enable(Enable), .IORW(IORW),
    .IOADDR(IOADDR), .RX_DATA(RX_DATA), .RDA(RDA), .FERR(FERR), .OERR(OERR)
  );

  always #5 clk = ~clk;

  // Baud tick every 4th clk.
  always @(posedge clk) ecnt <= ecnt + 2'd1;
  assign Enable = (ecnt == 2'd3);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("cyc_rx_data", RX_DATA, m_data);
      chk("cyc_rda", {7'd0, RDA}, {7'd0, m_rda});
      chk("cyc_ferr", {7'd0, FERR}, {7'd0, m_ferr});
      chk("cyc_oerr", {7'd0, OERR}, {7'd0, m_oerr});
    end
  end

  task automatic do_read();
    @(negedge clk);
    m_valid = 1'b0;
    IORW = 1'b1;
    IOADDR = 2'b00;
    @(negedge clk);
    IORW = 1'b0;
    m_rda = 1'b0;
    m_ferr = 1'b0;
    m_oerr = 1'b0;
    m_valid = 1'b1;
  endtask

  // Stop sample lands on the 613th posedge after the start bit begins on an
  // Enable-aligned edge: 2 sync + detect at 5, +32 to mid-start, +8*64 data, +64 stop.
  task automatic send_frame(input logic [7:0] b, input logic stopb, input int rd_at,
                            input int rst_at, input bit lat_chk);
    logic [9:0] fr;
    logic       pre_rda;
    fr = {stopb, b, 1'b0};
    @(negedge clk);
    while (ecnt != 2'd3) @(negedge clk);
    m_valid = 1'b0;
    pre_rda = m_rda;
    for (int c = 1; c <= 640; c++) begin
      RxD    = fr[(c-1)/64];
      IORW   = (c == rd_at);
      IOADDR = 2'b00;
      rst    = (c == rst_at);
      if (lat_chk && c == 613) chk("lat_rda_before", {7'd0, RDA}, {7'd0, pre_rda});
      if (lat_chk && c == 614) begin
        chk("lat_rda_after", {7'd0, RDA}, 8'd1);
        chk("lat_data_after", RX_DATA, b);
      end
      @(negedge clk);
      if (c == rst_at) begin
        rst = 1'b0;
        RxD = 1'b1;
        chk("rst_rx_data", RX_DATA, 8'h00);
        chk("rst_rda", {7'd0, RDA}, 8'd0);
        chk("rst_ferr", {7'd0, FERR}, 8'd0);
        chk("rst_oerr", {7'd0, OERR}, 8'd0);
        m_data = 8'h00; m_rda = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
        m_valid = 1'b1;
        repeat (80) @(negedge clk);
        return;
      end
    end
    IORW = 1'b0;
    RxD  = 1'b1;
    if (stopb) begin
      if (rd_at == 613) m_oerr = 1'b0;
      else if (m_rda) m_oerr = OV_EN;
      m_rda  = 1'b1;
      m_data = b;
      m_ferr = 1'b0;
    end else begin
      m_ferr = 1'b1;
    end
    m_valid = 1'b1;
    // Gap lets a held-low break restart and then reject itself before the next frame.
    repeat (80) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_rx_data", RX_DATA, 8'h00);
    chk("reset_rda", {7'd0, RDA}, 8'd0);
    chk("reset_ferr", {7'd0, FERR}, 8'd0);
    chk("reset_oerr", {7'd0, OERR}, 8'd0);
    m_valid = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(8'hA5, 1'b1, -1, -1, 1'b1);
    chk("a5_rda", {7'd0, RDA}, 8'd1);
    chk("a5_data", RX_DATA, 8'hA5);
    chk("a5_ferr", {7'd0, FERR}, 8'd0);
    do_read();
    chk("read_clr_rda", {7'd0, RDA}, 8'd0);
    chk("read_keeps_data", RX_DATA, 8'hA5);

    // Five-tick low glitch on the line.
    @(negedge clk);
    while (ecnt != 2'd3) @(negedge clk);
    RxD = 1'b0;
    repeat (20) @(negedge clk);
    RxD = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_rda", {7'd0, RDA}, 8'd0);
    chk("glitch_ferr", {7'd0, FERR}, 8'd0);
    send_frame(8'h3C, 1'b1, -1, -1, 1'b0);
    chk("3c_data", RX_DATA, 8'h3C);
    do_read();

    send_frame(8'h55, 1'b0, -1, -1, 1'b0);
    chk("ferr_set", {7'd0, FERR}, 8'd1);
    chk("ferr_rda", {7'd0, RDA}, 8'd0);
    chk("ferr_keeps_data", RX_DATA, 8'h3C);
    do_read();
    chk("ferr_cleared", {7'd0, FERR}, 8'd0);

    send_frame(8'h11, 1'b1, -1, -1, 1'b0);
    send_frame(8'h22, 1'b1, 613, -1, 1'b0);
    chk("race_rda", {7'd0, RDA}, 8'd1);
    chk("race_data", RX_DATA, 8'h22);
    chk("race_oerr", {7'd0, OERR}, 8'd0);
    do_read();

    send_frame(8'h11, 1'b1, -1, -1, 1'b0);
    send_frame(8'h22, 1'b1, -1, -1, 1'b0);
    chk("ovr_oerr", {7'd0, OERR}, {7'd0, OV_EN});
    chk("ovr_data", RX_DATA, 8'h22);

    // Reset lands while the receiver is collecting data bit 4.
    send_frame(8'h77, 1'b1, -1, 330, 1'b0);
    send_frame(8'hFF, 1'b1, -1, -1, 1'b0);
    chk("ff_data", RX_DATA, 8'hFF);
    chk("ff_rda", {7'd0, RDA}, 8'd1);

    repeat (5) @(negedge clk);
    m_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
